// File: rtl/homenc_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// homenc_cmd_sequencer_if
// Host -> sequencer command handshake.
//   cmd_valid  host command valid
//   cmd_ready  sequencer can accept a command (queue not full)
//   cmd_data   [24]=modulus_sel [23:20]=rdM0 [19:16]=rdM1
//              [15:12]=wtM0 [11:8]=wtM1 [7:0]=instruction
// master: host side, slave: sequencer side.
// ---------------------------------------------------------------------------
interface homenc_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [24:0] cmd_data;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/homenc_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// homenc_cmd_sequencer
// Command queue and issue controller for the two-core homomorphic
// coprocessor. Host commands are buffered in a FIFO and issued one at a
// time; done_in is ignored for a guard window after issue (stale-done
// protection), ops time out after 2^TO_W-1 wait cycles, and the instruction
// is parked at 0 for CLR_CYCLES after every op so the RLWE cores reset.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd               command handshake (slave side)
//   run_en            allow popping/issuing from IDLE
//   abort             pulse: flush queue, abandon current op
//   instruction, modulus_sel, rdM0, rdM1, wtM0, wtM1   coprocessor controls
//   done_in           coprocessor done level
//   host_grant        host may use cpu_interrupt/memory ports (IDLE only)
//   busy              op in flight or queue non-empty
//   fifo_count        queued command count
//   cmpl_pulse        one pulse per completed op (done or timeout)
//   cmpl_count        wrapping completed-op counter
//   err_timeout       sticky timeout flag, cleared by err_clr (set wins)
// ---------------------------------------------------------------------------
module homenc_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned CLR_CYCLES   = 2,
    parameter int unsigned TO_W         = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    homenc_cmd_sequencer_if.slave         cmd,
    input  logic                          run_en,
    input  logic                          abort,
    output logic [7:0]                    instruction,
    output logic                          modulus_sel,
    output logic [3:0]                    rdM0,
    output logic [3:0]                    rdM1,
    output logic [3:0]                    wtM0,
    output logic [3:0]                    wtM1,
    input  logic                          done_in,
    output logic                          host_grant,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          cmpl_pulse,
    output logic [15:0]                   cmpl_count,
    output logic                          err_timeout,
    input  logic                          err_clr
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = $clog2(GUARD_CYCLES);
    localparam int unsigned KW = $clog2(CLR_CYCLES + 1);
    localparam logic [GW-1:0]   G_LAST  = GW'(GUARD_CYCLES - 1);
    localparam logic [KW-1:0]   K_LAST  = KW'(CLR_CYCLES - 1);
    // One below all-ones: the increment out of this value "reaches" all-ones,
    // giving exactly 2^TO_W-1 wait cycles before the timeout fires.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CLEAR} state_t;

    state_t          state_q;
    logic [24:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q;
    logic [GW-1:0]   guard_q;
    logic [KW-1:0]   clr_q;
    logic [TO_W-1:0] to_q;
    logic [24:0]     cmd_q;
    logic            grant_q, pulse_q, err_q;
    logic [15:0]     ccount_q;

    logic [24:0] head;
    logic        push, pop, to_ev;

    // Count never exceeds FIFO_DEPTH, so its MSB alone flags "full".
    assign cmd.cmd_ready = ~cnt_q[AW];
    assign head  = mem[rd_q];
    assign push  = cmd.cmd_valid && !cnt_q[AW] && !abort;
    assign pop   = (state_q == S_IDLE) && run_en && (cnt_q != '0) && !abort;
    assign to_ev = (state_q == S_WAIT) && !abort && !done_in && (to_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= cmd.cmd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            guard_q  <= '0;
            clr_q    <= '0;
            to_q     <= '0;
            cmd_q    <= '0;
            grant_q  <= 1'b1;
            pulse_q  <= 1'b0;
            ccount_q <= '0;
            err_q    <= 1'b0;
        end else begin
            pulse_q <= 1'b0;

            if (abort) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + AW'(1);
                if (pop)  rd_q <= rd_q + AW'(1);
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + CW'(1);
                    2'b01:   cnt_q <= cnt_q - CW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end

            if (to_ev)        err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cmd_q   <= head;
                        grant_q <= 1'b0;
                        guard_q <= '0;
                        clr_q   <= '0;
                        state_q <= (head[7:0] == 8'd0) ? S_CLEAR : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        cmd_q[7:0] <= 8'd0;
                        clr_q      <= '0;
                        state_q    <= S_CLEAR;
                    end else if (guard_q == G_LAST) begin
                        to_q    <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        guard_q <= guard_q + GW'(1);
                    end
                end
                S_WAIT: begin
                    if (abort || done_in || (to_q == TO_LAST)) begin
                        cmd_q[7:0] <= 8'd0;
                        clr_q      <= '0;
                        state_q    <= S_CLEAR;
                        if (!abort) begin
                            pulse_q  <= 1'b1;
                            ccount_q <= ccount_q + 16'd1;
                        end
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                S_CLEAR: begin
                    if (clr_q == K_LAST) begin
                        grant_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        clr_q <= clr_q + KW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instruction = cmd_q[7:0];
    assign modulus_sel = cmd_q[24];
    assign rdM0        = cmd_q[23:20];
    assign rdM1        = cmd_q[19:16];
    assign wtM0        = cmd_q[15:12];
    assign wtM1        = cmd_q[11:8];
    assign host_grant  = grant_q;
    assign busy        = (state_q != S_IDLE) || (cnt_q != '0);
    assign fifo_count  = cnt_q;
    assign cmpl_pulse  = pulse_q;
    assign cmpl_count  = ccount_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_homenc_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_homenc_cmd_sequencer
// Directed scenario sequence with randomized command payloads and done
// delays. A behavioural model (command queue + "op age since issue") predicts
// every output each cycle.
// ---------------------------------------------------------------------------
module tb_homenc_cmd_sequencer;
    localparam int DEPTH  = 16;
    localparam int G      = 4;
    localparam int CLR    = 2;
    localparam int TOW    = 4;
    localparam int TO_LIM = (1 << TOW) - 1;

    logic        clk = 1'b0;
    logic        rst_n, run_en, abort, done_in, err_clr;
    logic [7:0]  instruction;
    logic        modulus_sel;
    logic [3:0]  rdM0, rdM1, wtM0, wtM1;
    logic        host_grant, busy, cmpl_pulse, err_timeout;
    logic [4:0]  fifo_count;
    logic [15:0] cmpl_count;

    homenc_cmd_sequencer_if cif ();

    homenc_cmd_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .GUARD_CYCLES(G),
        .CLR_CYCLES  (CLR),
        .TO_W        (TOW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cif.slave),
        .run_en     (run_en),
        .abort      (abort),
        .instruction(instruction),
        .modulus_sel(modulus_sel),
        .rdM0       (rdM0),
        .rdM1       (rdM1),
        .wtM0       (wtM0),
        .wtM1       (wtM1),
        .done_in    (done_in),
        .host_grant (host_grant),
        .busy       (busy),
        .fifo_count (fifo_count),
        .cmpl_pulse (cmpl_pulse),
        .cmpl_count (cmpl_count),
        .err_timeout(err_timeout),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_mode: 0 = idle, 1 = op in flight (issue+wait merged, tracked by age), 2 = parked
    logic [24:0] q[$];
    int          m_mode, m_age, m_clr;
    logic [24:0] m_out;
    bit          m_grant, m_pulse, m_err;
    logic [15:0] m_cnt;

    int total = 0;
    int bad   = 0;
    int dpol;          // 0: done low, 1: done high, 2: done once op age >= done_delay
    int done_delay;
    bit rnd_delay;

    task automatic model_reset();
        q.delete();
        m_mode = 0; m_age = 0; m_clr = 0;
        m_out = '0; m_grant = 1'b1; m_pulse = 1'b0; m_err = 1'b0; m_cnt = '0;
    endtask

    task automatic model_edge();
        bit psh, pp, dn_ev, to_ev;
        logic [24:0] cur;
        psh   = cif.cmd_valid && (q.size() < DEPTH) && !abort;
        pp    = (m_mode == 0) && run_en && (q.size() > 0) && !abort;
        dn_ev = 1'b0;
        to_ev = 1'b0;
        m_pulse = 1'b0;
        case (m_mode)
            0: if (pp) begin
                cur = q.pop_front();
                m_out = cur; m_grant = 1'b0; m_age = 0; m_clr = 0;
                m_mode = (cur[7:0] == 8'd0) ? 2 : 1;
                if (rnd_delay) done_delay = $urandom_range(2, 12);
            end
            1: if (abort) begin
                m_out[7:0] = 8'd0; m_mode = 2; m_clr = 0;
            end else if (m_age >= G && done_in) dn_ev = 1'b1;
            else if (m_age == G + TO_LIM - 1) to_ev = 1'b1;
            else m_age++;
            default: begin
                m_clr++;
                if (m_clr == CLR) begin m_mode = 0; m_grant = 1'b1; end
            end
        endcase
        if (dn_ev || to_ev) begin
            m_out[7:0] = 8'd0; m_mode = 2; m_clr = 0; m_pulse = 1'b1; m_cnt++;
        end
        if (abort) q.delete();
        else if (psh) q.push_back(cif.cmd_data);
        if (to_ev) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("instruction", 32'(instruction), 32'(m_out[7:0]));
        chk("fields", 32'({modulus_sel, rdM0, rdM1, wtM0, wtM1}), 32'(m_out[24:8]));
        chk("host_grant", 32'(host_grant), 32'(m_grant));
        chk("busy", 32'(busy), 32'(m_mode != 0 || q.size() != 0));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("cmd_ready", 32'(cif.cmd_ready), 32'(q.size() < DEPTH));
        chk("cmpl_pulse", 32'(cmpl_pulse), 32'(m_pulse));
        chk("cmpl_count", 32'(cmpl_count), 32'(m_cnt));
        chk("err_timeout", 32'(err_timeout), 32'(m_err));
    endtask

    task automatic tick();
        case (dpol)
            0:       done_in = 1'b0;
            1:       done_in = 1'b1;
            default: done_in = (m_mode == 1) && (m_age >= done_delay);
        endcase
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic push(input logic [24:0] d);
        cif.cmd_valid = 1'b1;
        cif.cmd_data  = d;
        tick();
        cif.cmd_valid = 1'b0;
    endtask

    task automatic run_until_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (m_mode == 0 && q.size() == 0) break;
            tick();
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    function automatic logic [24:0] rnd_cmd();
        logic [24:0] d;
        d = 25'($urandom);
        if (d[7:0] == 8'd0) d[7:0] = 8'd1;
        return d;
    endfunction

    initial begin
        logic [24:0] d;
        rst_n = 1'b0; run_en = 1'b1; abort = 1'b0; done_in = 1'b0; err_clr = 1'b0;
        cif.cmd_valid = 1'b0; cif.cmd_data = '0;
        dpol = 0; done_delay = 0; rnd_delay = 1'b0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        tick();

        // 1: single op, done 10 cycles after issue
        dpol = 2; done_delay = 10;
        push({1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 8'd5});
        run_until_idle(60);

        // 2: done already high -> ignored through the guard window
        dpol = 1;
        d = rnd_cmd(); d[7:0] = 8'd2;
        push(d);
        run_until_idle(60);
        dpol = 0;
        tick();

        // 3: fill queue while paused, then drain in order
        run_en = 1'b0; dpol = 2; rnd_delay = 1'b1;
        for (int i = 0; i < 17; i++) push(rnd_cmd());
        chk("full_count", 32'(fifo_count), 32'd16);
        chk("full_ready", 32'(cif.cmd_ready), 32'd0);
        run_en = 1'b1;
        run_until_idle(1000);
        rnd_delay = 1'b0;

        // 4: timeouts; second timeout collides with a held err_clr
        dpol = 0;
        push(rnd_cmd());
        push(rnd_cmd());
        for (int i = 0; i < 100; i++) begin
            if (m_err) break;
            tick();
        end
        chk("err_set", 32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        run_until_idle(200);
        tick();
        err_clr = 1'b0;
        tick();

        // 5: abort during WAIT with 3 queued, plus a push in the abort cycle
        for (int i = 0; i < 4; i++) push(rnd_cmd());
        for (int i = 0; i < 50; i++) begin
            if (m_mode == 1 && m_age >= G + 2) break;
            tick();
        end
        abort = 1'b1;
        cif.cmd_valid = 1'b1; cif.cmd_data = rnd_cmd();
        tick();
        abort = 1'b0; cif.cmd_valid = 1'b0;
        chk("abort_flush", 32'(fifo_count), 32'd0);
        chk("abort_instr", 32'(instruction), 32'd0);
        run_until_idle(20);

        // 6: NOP followed by instr=6
        dpol = 2; done_delay = 5;
        d = rnd_cmd(); d[7:0] = 8'd0;
        push(d);
        d = rnd_cmd(); d[7:0] = 8'd6;
        push(d);
        run_until_idle(60);

        // 7: asynchronous reset mid-op
        dpol = 0;
        push(rnd_cmd());
        push(rnd_cmd());
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_instr", 32'(instruction), 32'd0);
        chk("async_count", 32'(fifo_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
